fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port: PC_write_en  input  1  from hazard unit; 0 = hold PC (stall).
REQ-004 SHALL have port: IFID_write_en  input  1  from hazard unit; 0 = hold IF/ID register.
REQ-005 SHALL have port: Branch_taken  input  1  branch/B/BR resolved taken in ID this cycle.
REQ-006 SHALL have port: Branch_target  input  16  redirect PC value, valid with Branch_taken.
REQ-007 SHALL have port: Imem_data  input  16  instruction word read combinationally at Imem_addr.
REQ-008 SHALL have port: Imem_addr  output  16  current PC.
REQ-009 SHALL have port: IFID_instr  output  16  registered instruction presented to ID.
REQ-010 SHALL have port: IFID_PC_plus2  output  16  registered PC+2 of that instruction.
REQ-011 SHALL have port: IFID_valid  output  1  1 = IFID_instr is a real instruction, 0 = bubble.
REQ-012 SHALL have port: Halted  output  1  1 once HLT has drained through WB; sticky until reset.

Function
REQ-013 SHALL compute PC+2 as 16-bit unsigned add, wrapping 0xFFFE -> 0x0000.
REQ-014 SHALL, per cycle in RUN, update PC with priority: stall (PC_write_en=0: hold) > Branch_taken (load Branch_target) > sequential (PC+2).
REQ-015 SHALL, with Branch_taken=1 and PC_write_en=0, ignore the branch; ID re-presents it next cycle.
REQ-016 SHALL, when IFID_write_en=1 and Branch_taken=1, load IF/ID with bubble: instr 0x0000, valid 0, PC_plus2 0x0000 (flush wrong-path fetch).
REQ-017 SHALL, when IFID_write_en=1 and no flush, load IF/ID with Imem_data, PC+2, valid 1.
REQ-018 SHALL, when IFID_write_en=0, hold all IF/ID outputs unchanged, including during flush requests.
REQ-019 SHALL implement FSM states RUN, DRAIN, HALTED.
REQ-020 SHALL transition RUN -> DRAIN when Imem_data[15:12]=4'b1111 and IFID_write_en=1 and PC_write_en=1 and Branch_taken=0; HLT is latched into IF/ID that edge; PC holds (not incremented).
REQ-021 SHALL treat HLT fetched while Branch_taken=1 as flushed: no state change.
REQ-022 SHALL, in DRAIN and HALTED, freeze PC and load bubbles into IF/ID whenever IFID_write_en=1.
REQ-023 SHALL load a 2-bit drain counter with 3 on entering DRAIN, decrement only on cycles with IFID_write_en=1, and move DRAIN -> HALTED on the cycle it decrements from 0 (HLT has passed ID, EX, MEM, WB).
REQ-024 SHALL assert Halted combinationally from state==HALTED only; HALTED exits only via reset.
REQ-025 SHALL ignore Branch_taken in DRAIN and HALTED.

Reset
REQ-026 SHALL, on rst_n=0 at a clock edge, set PC=0x0000, IFID_instr=0x0000, IFID_PC_plus2=0x0000, IFID_valid=0, state=RUN, drain counter=0, Halted=0.
REQ-027 SHALL let reset override every other input, including mid-DRAIN and in HALTED.
REQ-028 SHALL fetch address 0x0000 in the first cycle after rst_n returns high.

Structure
REQ-029 SHALL take opcode constants (OP_B=4'b1100, OP_BR=4'b1101, OP_HLT=4'b1111), NOP word 0x0000 and reset PC 0x0000 from the shared CPU constants package.
REQ-030 SHALL instantiate one sub-module pc_register: 16-bit, synchronous active-low reset to 0x0000, write enable, data in.
REQ-031 SHALL keep the FSM and IF/ID register in fetch_stage itself; no combinational path from Branch_target to IF/ID outputs.

Verification
REQ-032 SHALL cover sequential fetch: reset, imem returns 0x1234 at every address, all enables 1 -> Imem_addr 0x0000, 0x0002, 0x0004; IFID_PC_plus2 0x0002, 0x0004; valid 1.
REQ-033 SHALL cover stall: PC=0x0010, PC_write_en=IFID_write_en=0 for 2 cycles -> Imem_addr stays 0x0010, IF/ID outputs unchanged, then resumes 0x0012.
REQ-034 SHALL cover branch flush: PC=0x0020, Branch_taken=1, target 0x0100 -> next Imem_addr 0x0100, IFID_valid 0, IFID_instr 0x0000; Branch_taken with PC_write_en=0 -> PC holds 0x0020.
REQ-035 SHALL cover halt: HLT (0xF000) at 0x0030, no stalls -> IFID_instr 0xF000 next cycle, PC frozen at 0x0030, Halted=1 exactly 4 cycles after HLT latched; one stall cycle in DRAIN delays Halted by 1.
REQ-036 SHALL cover HLT on wrong path: HLT fetched while Branch_taken=1 -> state stays RUN, Halted stays 0, PC = target.
REQ-037 SHALL cover PC wrap and reset in HALTED: PC 0xFFFE sequential -> 0x0000; rst_n=0 while Halted=1 -> Halted 0, PC 0x0000 next cycle.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants for the fetch stage: opcodes, NOP word, reset PC,
// fetch FSM state encoding and the PC increment helper.
package fetch_stage_pkg;

  localparam int          XLEN     = 16;
  localparam logic [3:0]  OP_B     = 4'b1100;
  localparam logic [3:0]  OP_BR    = 4'b1101;
  localparam logic [3:0]  OP_HLT   = 4'b1111;
  localparam logic [15:0] NOP_WORD = 16'h0000;
  localparam logic [15:0] RESET_PC = 16'h0000;

  // Pipeline stages HLT must still pass after it enters IF/ID (ID, EX, MEM, WB).
  localparam logic [1:0]  DRAIN_LOAD = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Unsigned 16-bit add; 0xFFFE wraps to 0x0000.
  function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: hazard-unit controls, branch redirect, instruction memory
// port and the IF/ID register outputs.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic        PC_write_en;
  logic        IFID_write_en;
  logic        Branch_taken;
  logic [15:0] Branch_target;
  logic [15:0] Imem_data;
  logic [15:0] Imem_addr;
  logic [15:0] IFID_instr;
  logic [15:0] IFID_PC_plus2;
  logic        IFID_valid;
  logic        Halted;

  modport master (
    output PC_write_en, IFID_write_en, Branch_taken, Branch_target, Imem_data,
    input  Imem_addr, IFID_instr, IFID_PC_plus2, IFID_valid, Halted
  );

  modport slave (
    input  PC_write_en, IFID_write_en, Branch_taken, Branch_target, Imem_data,
    output Imem_addr, IFID_instr, IFID_PC_plus2, IFID_valid, Halted
  );

endinterface

// File: rtl/fetch_stage_pc_register.sv
// Program counter: 16-bit register with write enable and synchronous
// active-low reset to the reset PC.
module pc_register
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [15:0] i_d,
  output logic [15:0] o_q
);

  logic [15:0] r_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_we) begin
      r_pc <= i_d;
    end
  end

  assign o_q = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC update, IF/ID pipeline register and the
// RUN/DRAIN/HALTED FSM that stops fetching once HLT has retired.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.slave  bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [1:0]   r_drain_cnt;
  logic [1:0]   w_drain_cnt_next;

  logic [15:0]  r_ifid_instr;
  logic [15:0]  r_ifid_pc_plus2;
  logic         r_ifid_valid;
  logic [15:0]  w_ifid_instr_next;
  logic [15:0]  w_ifid_pc_plus2_next;
  logic         w_ifid_valid_next;

  logic [15:0]  w_pc;
  logic [15:0]  w_pc_plus2;
  logic [15:0]  w_pc_d;
  logic         w_pc_we;
  logic         w_run;
  logic         w_hlt_fetch;

  assign w_run      = (r_state == ST_RUN);
  assign w_pc_plus2 = pc_plus2(w_pc);

  // HLT only counts when it is actually committed into IF/ID this edge.
  assign w_hlt_fetch = w_run && (bus.Imem_data[15:12] == OP_HLT) &&
                       bus.IFID_write_en && bus.PC_write_en && !bus.Branch_taken;

  assign w_pc_we = w_run && bus.PC_write_en && !w_hlt_fetch;
  assign w_pc_d  = bus.Branch_taken ? bus.Branch_target : w_pc_plus2;

  pc_register u_pc_register (
    .clk   (clk),
    .rst_n (rst_n),
    .i_we  (w_pc_we),
    .i_d   (w_pc_d),
    .o_q   (w_pc)
  );

  always_comb begin
    w_state_next     = r_state;
    w_drain_cnt_next = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_hlt_fetch) begin
          w_state_next     = ST_DRAIN;
          w_drain_cnt_next = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (bus.IFID_write_en) begin
          if (r_drain_cnt == 2'd0) begin
            w_state_next = ST_HALTED;
          end else begin
            w_drain_cnt_next = r_drain_cnt - 2'd1;
          end
        end
      end
      ST_HALTED: begin
        w_state_next = ST_HALTED;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // Wrong-path fetches and everything after HLT enter IF/ID as bubbles.
  always_comb begin
    w_ifid_instr_next    = r_ifid_instr;
    w_ifid_pc_plus2_next = r_ifid_pc_plus2;
    w_ifid_valid_next    = r_ifid_valid;
    if (bus.IFID_write_en) begin
      if (!w_run || bus.Branch_taken) begin
        w_ifid_instr_next    = NOP_WORD;
        w_ifid_pc_plus2_next = 16'h0000;
        w_ifid_valid_next    = 1'b0;
      end else begin
        w_ifid_instr_next    = bus.Imem_data;
        w_ifid_pc_plus2_next = w_pc_plus2;
        w_ifid_valid_next    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= ST_RUN;
      r_drain_cnt     <= 2'd0;
      r_ifid_instr    <= NOP_WORD;
      r_ifid_pc_plus2 <= 16'h0000;
      r_ifid_valid    <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_drain_cnt     <= w_drain_cnt_next;
      r_ifid_instr    <= w_ifid_instr_next;
      r_ifid_pc_plus2 <= w_ifid_pc_plus2_next;
      r_ifid_valid    <= w_ifid_valid_next;
    end
  end

  assign bus.Imem_addr     = w_pc;
  assign bus.IFID_instr    = r_ifid_instr;
  assign bus.IFID_PC_plus2 = r_ifid_pc_plus2;
  assign bus.IFID_valid    = r_ifid_valid;
  assign bus.Halted        = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: sequential fetch, stall, branch flush,
// halt drain timing, wrong-path HLT, PC wrap and reset out of HALTED.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic        hlt_en   = 1'b0;
  logic [15:0] hlt_addr = 16'h0030;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: 0x1234 everywhere, optionally HLT at hlt_addr.
  always_comb begin
    bus.Imem_data = (hlt_en && bus.Imem_addr == hlt_addr) ? 16'hF000 : 16'h1234;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] instr,
                          input logic [15:0] pc2, input logic valid);
    chk({tag, ".instr"}, bus.IFID_instr, instr);
    chk({tag, ".pc2"}, bus.IFID_PC_plus2, pc2);
    chk({tag, ".valid"}, {15'd0, bus.IFID_valid}, {15'd0, valid});
  endtask

  task automatic chk_halt(input string tag, input logic exp);
    chk(tag, {15'd0, bus.Halted}, {15'd0, exp});
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.PC_write_en   = 1'b1;
    bus.IFID_write_en = 1'b1;
    bus.Branch_taken  = 1'b0;
    bus.Branch_target = 16'h0000;

    // Reset state
    step(); step();
    chk("rst.addr", bus.Imem_addr, 16'h0000);
    chk_ifid("rst", 16'h0000, 16'h0000, 1'b0);
    chk_halt("rst.halted", 1'b0);
    $display("reset: addr=%h valid=%b halted=%b", bus.Imem_addr, bus.IFID_valid, bus.Halted);

    // Sequential fetch
    rst_n = 1'b1;
    chk("seq.addr0", bus.Imem_addr, 16'h0000);
    step();
    chk("seq.addr1", bus.Imem_addr, 16'h0002);
    chk_ifid("seq1", 16'h1234, 16'h0002, 1'b1);
    step();
    chk("seq.addr2", bus.Imem_addr, 16'h0004);
    chk_ifid("seq2", 16'h1234, 16'h0004, 1'b1);
    $display("seq: addr=%h ifid_pc2=%h", bus.Imem_addr, bus.IFID_PC_plus2);

    // Advance to PC=0x0010, then stall two cycles
    repeat (6) step();
    chk("stall.pre", bus.Imem_addr, 16'h0010);
    bus.PC_write_en   = 1'b0;
    bus.IFID_write_en = 1'b0;
    step();
    chk("stall.addr1", bus.Imem_addr, 16'h0010);
    chk_ifid("stall1", 16'h1234, 16'h0010, 1'b1);
    step();
    chk("stall.addr2", bus.Imem_addr, 16'h0010);
    chk_ifid("stall2", 16'h1234, 16'h0010, 1'b1);
    bus.PC_write_en   = 1'b1;
    bus.IFID_write_en = 1'b1;
    step();
    chk("stall.resume", bus.Imem_addr, 16'h0012);
    chk_ifid("resume", 16'h1234, 16'h0012, 1'b1);
    $display("stall: addr=%h ifid_pc2=%h", bus.Imem_addr, bus.IFID_PC_plus2);

    // Branch to 0x0020 flushes IF/ID
    bus.Branch_taken  = 1'b1;
    bus.Branch_target = 16'h0020;
    step();
    chk("br.addr", bus.Imem_addr, 16'h0020);
    chk_ifid("br.flush", 16'h0000, 16'h0000, 1'b0);
    // Branch while PC stalled: ignored, PC holds
    bus.Branch_target = 16'h0100;
    bus.PC_write_en   = 1'b0;
    step();
    chk("br.stall_hold", bus.Imem_addr, 16'h0020);
    bus.PC_write_en = 1'b1;
    step();
    chk("br.addr2", bus.Imem_addr, 16'h0100);
    chk_ifid("br.flush2", 16'h0000, 16'h0000, 1'b0);
    bus.Branch_taken = 1'b0;
    step();
    chk("br.seq", bus.Imem_addr, 16'h0102);
    chk_ifid("br.seq", 16'h1234, 16'h0102, 1'b1);
    // Flush request with IFID_write_en=0: IF/ID holds
    bus.Branch_taken  = 1'b1;
    bus.Branch_target = 16'h0030;
    bus.IFID_write_en = 1'b0;
    step();
    chk("br.hold_addr", bus.Imem_addr, 16'h0030);
    chk_ifid("br.hold", 16'h1234, 16'h0102, 1'b1);
    $display("branch: addr=%h ifid_valid=%b", bus.Imem_addr, bus.IFID_valid);

    // HLT fetched on wrong path: flushed, still RUN
    hlt_en            = 1'b1;
    bus.IFID_write_en = 1'b1;
    bus.Branch_target = 16'h0040;
    step();
    chk("wp.addr", bus.Imem_addr, 16'h0040);
    chk_ifid("wp", 16'h0000, 16'h0000, 1'b0);
    chk_halt("wp.halted", 1'b0);
    bus.Branch_taken = 1'b0;
    step();
    chk("wp.run", bus.Imem_addr, 16'h0042);
    chk_halt("wp.halted2", 1'b0);
    $display("wrongpath hlt: addr=%h halted=%b", bus.Imem_addr, bus.Halted);

    // Real HLT at 0x0030, no stalls
    bus.Branch_taken  = 1'b1;
    bus.Branch_target = 16'h0030;
    step();
    chk("hlt.addr", bus.Imem_addr, 16'h0030);
    bus.Branch_taken = 1'b0;
    step();  // HLT latched
    chk_ifid("hlt.latch", 16'hF000, 16'h0032, 1'b1);
    chk("hlt.pc0", bus.Imem_addr, 16'h0030);
    chk_halt("hlt.h0", 1'b0);
    step();
    chk_ifid("hlt.bub", 16'h0000, 16'h0000, 1'b0);
    chk("hlt.pc1", bus.Imem_addr, 16'h0030);
    chk_halt("hlt.h1", 1'b0);
    bus.Branch_taken  = 1'b1;  // ignored in DRAIN
    bus.Branch_target = 16'h0200;
    step();
    chk("hlt.pc2", bus.Imem_addr, 16'h0030);
    chk_halt("hlt.h2", 1'b0);
    step();
    chk_halt("hlt.h3", 1'b0);
    step();
    chk_halt("hlt.h4", 1'b1);
    chk("hlt.pc4", bus.Imem_addr, 16'h0030);
    bus.Branch_taken = 1'b0;
    step();
    chk_halt("hlt.sticky", 1'b1);
    chk("hlt.pc5", bus.Imem_addr, 16'h0030);
    $display("halt: addr=%h halted=%b", bus.Imem_addr, bus.Halted);

    // Reset out of HALTED
    rst_n = 1'b0;
    step();
    chk_halt("rsth.halted", 1'b0);
    chk("rsth.addr", bus.Imem_addr, 16'h0000);
    rst_n = 1'b1;

    // Halt with one stall cycle in DRAIN
    bus.Branch_taken  = 1'b1;
    bus.Branch_target = 16'h0030;
    step();
    bus.Branch_taken = 1'b0;
    step();  // HLT latched
    chk_ifid("hlt2.latch", 16'hF000, 16'h0032, 1'b1);
    step(); step();
    bus.IFID_write_en = 1'b0;
    step();
    chk_halt("hlt2.stall", 1'b0);
    bus.IFID_write_en = 1'b1;
    step();
    chk_halt("hlt2.h4", 1'b0);
    step();
    chk_halt("hlt2.h5", 1'b1);
    $display("halt+stall: halted=%b", bus.Halted);

    // PC wrap
    hlt_en = 1'b0;
    rst_n  = 1'b0;
    step();
    rst_n             = 1'b1;
    bus.Branch_taken  = 1'b1;
    bus.Branch_target = 16'hFFFE;
    step();
    chk("wrap.pre", bus.Imem_addr, 16'hFFFE);
    bus.Branch_taken = 1'b0;
    step();
    chk("wrap.addr", bus.Imem_addr, 16'h0000);
    chk_ifid("wrap", 16'h1234, 16'h0000, 1'b1);
    $display("wrap: addr=%h ifid_pc2=%h", bus.Imem_addr, bus.IFID_PC_plus2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
